// File: rtl/lbp_hist.sv
// lbp_hist: 256-bin histogram of LBP codes for one 128x128 frame.
//
// Snoops the LBP engine's write port and counts each code in a 256 x CNT_W
// bin array with a synchronous read. Counting goes through a read-modify-write
// pipeline. A bypass lets back-to-back samples of the same code count
// correctly at one sample per cycle. When the engine signals finish, the
// block streams bins 0..255 out over a valid/ready port and then raises
// hist_done.
//
// Bins are never swept clear. A per-bin "touched" flag, cleared on reset,
// makes an untouched bin read as zero.
//
// Optional feature macro: LBP_HIST_SKIP_BORDER_EN
//   Defined   : samples whose row or col is 0 or 127 are not counted.
//   Undefined : every lbp_valid sample is counted.
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   lbp_valid  in   upstream LBP result strobe
//   lbp_addr   in   upstream pixel address {row[6:0], col[6:0]}
//   lbp_data   in   upstream LBP code (bin index)
//   finish     in   upstream frame-complete level
//   hist_valid out  hist_bin/hist_count valid
//   hist_ready in   downstream accepts current bin
//   hist_bin   out  bin index being output
//   hist_count out  count for hist_bin
//   hist_done  out  all bins delivered; held until reset
module lbp_hist #(
    parameter int unsigned CNT_W = 15,
    parameter int unsigned BINS  = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             lbp_valid,
    input  logic [13:0]      lbp_addr,
    input  logic [7:0]       lbp_data,
    input  logic             finish,
    output logic             hist_valid,
    input  logic             hist_ready,
    output logic [7:0]       hist_bin,
    output logic [CNT_W-1:0] hist_count,
    output logic             hist_done
);

    typedef enum logic [1:0] {StAccum, StDrain, StDone} state_e;

    state_e state_q, state_d;

    logic [CNT_W-1:0] mem [BINS];
    logic [CNT_W-1:0] rdata_q;
    logic [BINS-1:0]  touched_q;
    logic [7:0]       raddr;

    logic             s1_valid_q;
    logic [7:0]       s1_bin_q;
    logic             s2_valid_q;
    logic [7:0]       s2_bin_q;
    logic [CNT_W-1:0] s2_cnt_q;
    logic [CNT_W-1:0] old_cnt, new_cnt;
    logic             accept, border, wr_en;

    logic [7:0]       drain_bin_q, drain_bin_d;
    logic             hist_valid_q, hist_valid_d;
    logic             done_q, done_d;

`ifdef LBP_HIST_SKIP_BORDER_EN
    logic [6:0] row, col;
    assign row    = lbp_addr[13:7];
    assign col    = lbp_addr[6:0];
    assign border = (row == 7'd0) || (row == 7'd127) || (col == 7'd0) || (col == 7'd127);
`else
    logic unused_addr;
    assign unused_addr = ^lbp_addr;
    assign border      = 1'b0;
`endif

    assign accept = (state_q == StAccum) && lbp_valid && !border;

    // The array is written on the edge that ends S1, so a sample read on that
    // same edge sees stale data. It then takes the value from the S2 register
    // instead.
    always_comb begin
        if (s2_valid_q && (s2_bin_q == s1_bin_q)) begin
            old_cnt = s2_cnt_q;
        end else if (touched_q[s1_bin_q]) begin
            old_cnt = rdata_q;
        end else begin
            old_cnt = '0;
        end
        new_cnt = (old_cnt == {CNT_W{1'b1}}) ? old_cnt : old_cnt + CNT_W'(1);
    end

    assign wr_en = s1_valid_q && !reset;
    assign raddr = (state_q == StDrain) ? drain_bin_d : lbp_data;

    // Bin array: no reset; validity comes from touched_q.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[s1_bin_q] <= new_cnt;
        end
        rdata_q <= mem[raddr];
    end

    always_comb begin
        state_d      = state_q;
        drain_bin_d  = drain_bin_q;
        hist_valid_d = hist_valid_q;
        done_d       = done_q;
        unique case (state_q)
            StAccum: begin
                // A sample accepted this cycle must reach the array first.
                if (finish && !accept && !s1_valid_q && !s2_valid_q) begin
                    state_d      = StDrain;
                    drain_bin_d  = 8'd0;
                    hist_valid_d = 1'b0;
                end
            end
            StDrain: begin
                if (!hist_valid_q) begin
                    // Read of drain_bin_q is issued this cycle.
                    hist_valid_d = 1'b1;
                end else if (hist_ready) begin
                    if (drain_bin_q == 8'(BINS - 1)) begin
                        hist_valid_d = 1'b0;
                        done_d       = 1'b1;
                        state_d      = StDone;
                    end else begin
                        drain_bin_d = drain_bin_q + 8'd1;
                    end
                end
            end
            StDone: begin
            end
            default: state_d = StAccum;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StAccum;
            s1_valid_q   <= 1'b0;
            s1_bin_q     <= 8'd0;
            s2_valid_q   <= 1'b0;
            s2_bin_q     <= 8'd0;
            s2_cnt_q     <= '0;
            touched_q    <= '0;
            drain_bin_q  <= 8'd0;
            hist_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            s1_valid_q   <= accept;
            s1_bin_q     <= lbp_data;
            s2_valid_q   <= s1_valid_q;
            s2_bin_q     <= s1_bin_q;
            s2_cnt_q     <= new_cnt;
            if (s1_valid_q) begin
                touched_q[s1_bin_q] <= 1'b1;
            end
            drain_bin_q  <= drain_bin_d;
            hist_valid_q <= hist_valid_d;
            done_q       <= done_d;
        end
    end

    assign hist_valid = hist_valid_q;
    assign hist_bin   = drain_bin_q;
    assign hist_count = (hist_valid_q && touched_q[drain_bin_q]) ? rdata_q : '0;
    assign hist_done  = done_q;

endmodule

// File: tb/tb_lbp_hist.sv
// Self-checking bench for lbp_hist: a reference histogram is built from the
// samples sent; at finish the 256 expected bins are queued and a monitor
// compares every presented bin against the queue head.
module tb_lbp_hist;

    localparam int unsigned CNT_W   = 15;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    logic             clk        = 1'b0;
    logic             reset      = 1'b1;
    logic             lbp_valid  = 1'b0;
    logic [13:0]      lbp_addr   = '0;
    logic [7:0]       lbp_data   = '0;
    logic             finish     = 1'b0;
    logic             hist_ready = 1'b0;
    logic             hist_valid;
    logic [7:0]       hist_bin;
    logic [CNT_W-1:0] hist_count;
    logic             hist_done;

    int          checks = 0;
    int          errors = 0;
    int unsigned model [256];
    int unsigned exp_bin [$];
    int unsigned exp_cnt [$];
    int          bp_mode = 0;
    int          bp_cnt  = 0;

    lbp_hist #(.CNT_W(CNT_W), .BINS(256)) dut (
        .clk        (clk),
        .reset      (reset),
        .lbp_valid  (lbp_valid),
        .lbp_addr   (lbp_addr),
        .lbp_data   (lbp_data),
        .finish     (finish),
        .hist_valid (hist_valid),
        .hist_ready (hist_ready),
        .hist_bin   (hist_bin),
        .hist_count (hist_count),
        .hist_done  (hist_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Whether a pixel at this address contributes to the histogram.
    function automatic bit counted(input logic [13:0] a);
`ifdef LBP_HIST_SKIP_BORDER_EN
        int r;
        int c;
        r = int'(a) / 128;
        c = int'(a) % 128;
        return !(r == 0 || r == 127 || c == 0 || c == 127);
`else
        return int'(a) < 16384;
`endif
    endfunction

    task automatic send(input logic [13:0] a, input logic [7:0] d, input bit fin);
        @(posedge clk);
        #1;
        lbp_valid = 1'b1;
        lbp_addr  = a;
        lbp_data  = d;
        finish    = fin;
        if (counted(a)) model[d]++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            lbp_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset     = 1'b1;
        lbp_valid = 1'b0;
        finish    = 1'b0;
        exp_bin.delete();
        exp_cnt.delete();
        for (int b = 0; b < 256; b++) model[b] = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic push_expected();
        for (int b = 0; b < 256; b++) begin
            exp_bin.push_back(b);
            exp_cnt.push_back(model[b] > CNT_MAX ? CNT_MAX : model[b]);
        end
    endtask

    // Raise finish (if not already), queue the expected bins, wait for done.
    task automatic drain(input string name);
        push_expected();
        @(posedge clk);
        #1;
        lbp_valid = 1'b0;
        finish    = 1'b1;
        for (int i = 0; i < 3000 && !hist_done; i++) @(negedge clk);
        @(negedge clk);
        chk({name, "_done"}, hist_done, 1);
        chk({name, "_valid_low"}, hist_valid, 0);
        chk({name, "_bins_left"}, exp_bin.size(), 0);
    endtask

    // Downstream ready: always high, or the 1,0,0,1 pattern.
    always @(posedge clk) begin
        #1;
        if (bp_mode == 0) begin
            hist_ready = 1'b1;
        end else begin
            hist_ready = (bp_cnt % 4 == 0) || (bp_cnt % 4 == 3);
            bp_cnt++;
        end
    end

    // Monitor: compare every presented bin, pop on acceptance.
    always @(negedge clk) begin
        if (!reset && hist_valid) begin
            if (exp_bin.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_bin: got bin %0d count %0d expected no output",
                         hist_bin, hist_count);
            end else begin
                chk("drain_bin", hist_bin, exp_bin[0]);
                chk("drain_count", hist_count, exp_cnt[0]);
                if (hist_ready) begin
                    void'(exp_bin.pop_front());
                    void'(exp_cnt.pop_front());
                end
            end
        end
    end

    initial begin
        int unsigned r;
        int unsigned c;
        for (int b = 0; b < 256; b++) model[b] = 0;

        // Reset state.
        do_reset();
        @(negedge clk);
        chk("rst_valid", hist_valid, 0);
        chk("rst_bin", hist_bin, 0);
        chk("rst_count", hist_count, 0);
        chk("rst_done", hist_done, 0);

        // Full frame of code 0.
        bp_mode = 0;
        for (int a = 0; a < 16384; a++) send(14'(a), 8'h00, 1'b0);
        drain("all_zero");
        do_reset();

        // Back-to-back identical codes through the bypass.
        for (int i = 0; i < 5; i++) send(14'(200 + i), 8'h5A, 1'b0);
        send(14'd300, 8'h03, 1'b0);
        for (int i = 0; i < 3; i++) send(14'(400 + i), 8'h5A, 1'b0);
        drain("bypass");
        do_reset();

        // Alternating codes, finish with the last sample.
        for (int i = 0; i < 100; i++)
            send(14'(1000 + i), (i % 2 == 0) ? 8'h11 : 8'h22, i == 99);
        drain("alt_finish");
        do_reset();

        // Random clustered codes with gaps, drained under backpressure.
        bp_mode = 1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) != 0) send(14'($urandom), 8'($urandom_range(0, 7)), 1'b0);
            else idle(1);
        end
        drain("rand_bp");
        do_reset();

        // Random full-range codes at full rate.
        bp_mode = 0;
        for (int i = 0; i < 800; i++) send(14'($urandom), 8'($urandom), 1'b0);
        drain("rand_full");
        do_reset();

        // Reset in mid-drain, then a fresh small frame.
        for (int i = 0; i < 300; i++) send(14'($urandom), 8'($urandom), 1'b0);
        push_expected();
        @(posedge clk);
        #1;
        lbp_valid = 1'b0;
        finish    = 1'b1;
        for (int i = 0; i < 2000 && !(hist_valid && hist_bin == 8'd100); i++) @(negedge clk);
        chk("reach_bin100", hist_bin, 100);
        do_reset();
        @(negedge clk);
        chk("midrst_valid", hist_valid, 0);
        chk("midrst_done", hist_done, 0);
        for (int i = 0; i < 10; i++) send(14'(130 + i), 8'hFF, 1'b0);
        drain("after_midrst");
        do_reset();

        // Border raster: code 0 on the border, 0x80 inside.
        for (int a = 0; a < 16384; a++) begin
            r = a / 128;
            c = a % 128;
            send(14'(a), (r == 0 || r == 127 || c == 0 || c == 127) ? 8'h00 : 8'h80, 1'b0);
        end
        drain("border");
        do_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
